// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of an SDRAM controller: port 0 is read-only and normally wins,
// port 1 reads/writes and is guaranteed a grant after STARVE_LIMIT consecutive port-0 wins.
module sdram_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic        CLOCK_50,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic [23:0] p0_addr,
   output logic        p0_ack,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [23:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic [31:0] p1_rdata,
   output logic [23:0] mem_address,
   output logic [31:0] mem_data_in,
   output logic        mem_req_read,
   output logic        mem_req_write,
   input  logic [31:0] mem_data_out,
   input  logic        mem_data_valid,
   input  logic        mem_write_complete,
   output logic        timeout_err,
   output logic        busy
);
   localparam int SW = (STARVE_LIMIT > 7)   ? $clog2(STARVE_LIMIT + 1) : 3;
   localparam int TW = (TIMEOUT > 255)      ? $clog2(TIMEOUT + 1)      : 8;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [31:0]   TMO_DATA   = 32'hDEADBEEF;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic        port_q, port_d;   // granted port: 0 or 1
   logic        we_q, we_d;
   logic [23:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
   logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
   logic        err_q, err_d;
   logic        armed_q;          // blocks a grant on the first edge after reset release
   logic        grant_p1;
   logic        done;

   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      tmo_d      = tmo_q;
      port_d     = port_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      p0_ack_d   = 1'b0;
      p1_ack_d   = 1'b0;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      err_d      = err_q;
      grant_p1   = p1_req && (!p0_req || (starve_q == STARVE_MAX));
      done       = we_q ? mem_write_complete : mem_data_valid;

      unique case (state_q)
         IDLE: begin
            if (armed_q && (p0_req || p1_req)) begin
               state_d = ISSUE;
               port_d  = grant_p1;
               if (grant_p1) begin
                  we_d     = p1_we;
                  addr_d   = p1_addr;
                  wdata_d  = p1_wdata;
                  starve_d = '0;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = p0_addr;
                  wdata_d = '0;
                  if (!p1_req)
                     starve_d = '0;
                  else if (starve_q != STARVE_MAX)
                     starve_d = starve_q + 1'b1;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            tmo_d   = '0;
         end
         WAIT: begin
            tmo_d = tmo_q + 1'b1;
            // A real completion beats a timeout landing on the same cycle.
            if (done) begin
               state_d = DRAIN;
               if (port_q) begin
                  p1_ack_d = 1'b1;
                  if (!we_q)
                     p1_rdata_d = mem_data_out;
               end else begin
                  p0_ack_d   = 1'b1;
                  p0_rdata_d = mem_data_out;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = DRAIN;
               err_d   = 1'b1;
               if (port_q) begin
                  p1_ack_d   = 1'b1;
                  p1_rdata_d = TMO_DATA;
               end else begin
                  p0_ack_d   = 1'b1;
                  p0_rdata_d = TMO_DATA;
               end
            end
         end
         DRAIN: begin
            if (!mem_data_valid && !mem_write_complete)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         starve_q   <= '0;
         tmo_q      <= '0;
         port_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
         err_q      <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         tmo_q      <= tmo_d;
         port_q     <= port_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         p0_ack_q   <= p0_ack_d;
         p1_ack_q   <= p1_ack_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
         err_q      <= err_d;
         armed_q    <= 1'b1;
      end
   end

   assign p0_ack        = p0_ack_q;
   assign p1_ack        = p1_ack_q;
   assign p0_rdata      = p0_rdata_q;
   assign p1_rdata      = p1_rdata_q;
   assign mem_address   = addr_q;
   assign mem_data_in   = wdata_q;
   assign mem_req_read  = (state_q == ISSUE) && !we_q;
   assign mem_req_write = (state_q == ISSUE) && we_q;
   assign timeout_err   = err_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive port-0 grants while port 1 is waiting.
REQ-002 SHALL have parameter TIMEOUT, default 255: max CLOCK_50 cycles spent in WAIT before abort.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 p0_req  in  1  port 0 read request (read-only port); p0_addr  in  24  word address.
REQ-006 p0_ack  out  1  one-cycle completion pulse; p0_rdata  out  32  read data, valid when p0_ack=1.
REQ-007 p1_req  in  1  port 1 request; p1_we  in  1  1=write, 0=read; p1_addr  in  24; p1_wdata  in  32.
REQ-008 p1_ack  out  1  one-cycle completion pulse; p1_rdata  out  32  valid when p1_ack=1 and the op was a read.
REQ-009 mem_address  out  24; mem_data_in  out  32; mem_req_read  out  1; mem_req_write  out  1  (controller command side).
REQ-010 mem_data_out  in  32; mem_data_valid  in  1; mem_write_complete  in  1  (controller completion side).
REQ-011 timeout_err  out  1  sticky error flag; busy  out  1  high in every state except IDLE.

Function
REQ-012 Requesters SHALL hold req, we, addr and wdata stable from assertion until the cycle of their ack; the arbiter samples all of them at grant.
REQ-013 States SHALL be IDLE, ISSUE, WAIT, DRAIN.
REQ-014 IDLE: when at least one request is pending, the arbiter SHALL grant, latch the winner's addr/we/wdata into mem_address/mem_data_in, and move to ISSUE.
REQ-015 Priority SHALL be port 0 first, except when starve_cnt==STARVE_LIMIT and p1_req=1, in which case port 1 SHALL win.
REQ-016 starve_cnt rules (3-bit minimum, saturating at STARVE_LIMIT):
- increment on each port-0 grant while p1_req=1;
- clear on each port-1 grant;
- clear on any grant made while p1_req=0.
REQ-017 ISSUE: the arbiter SHALL assert mem_req_read (read) or mem_req_write (write) for exactly one cycle, then go to WAIT.
REQ-018 WAIT: on mem_data_valid=1 for a read, it SHALL capture mem_data_out into the granted port's rdata, pulse that port's ack for one cycle, and go to DRAIN.
REQ-019 WAIT: on mem_write_complete=1 for a write, it SHALL pulse p1_ack for one cycle and go to DRAIN.
REQ-020 A completion signal of the wrong type for the granted op SHALL be ignored while in WAIT.
REQ-021 DRAIN: it SHALL stay until mem_data_valid=0 and mem_write_complete=0, then go to IDLE, so that a multi-cycle completion level is never counted twice.
REQ-022 Timeout counter (8-bit minimum):
- clears on entry to WAIT;
- increments each cycle in WAIT;
- on reaching TIMEOUT: set timeout_err, pulse the granted port's ack with rdata=32'hDEADBEEF, go to DRAIN.
REQ-023 Completion and timeout in the same cycle: completion SHALL win and timeout_err SHALL remain unchanged.
REQ-024 mem_address and mem_data_in SHALL hold their values from grant until the next grant.
REQ-025 Back-to-back operation: at most one request SHALL be accepted per pass through IDLE; the minimum grant-to-grant spacing is 4 cycles (IDLE, ISSUE, WAIT with immediate completion, DRAIN).
REQ-026 A port's req deasserting before its ack is a protocol violation; behaviour is undefined and no checking is required.
REQ-027 timeout_err SHALL clear only on reset.

Reset
REQ-028 While rst_n=0, the following SHALL all be 0 and state SHALL be IDLE:
- all outputs;
- starve_cnt, the timeout counter, and the internal granted-port/op registers.
REQ-029 Reset asserted mid-operation SHALL abandon the op with no ack. After release, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-030 Single read: p0_req with p0_addr=24'h000123; controller returns mem_data_valid with 32'hCAFEF00D -> one mem_req_read pulse with mem_address=24'h000123, then one p0_ack pulse with p0_rdata=32'hCAFEF00D.
REQ-031 Write: p1_we=1, p1_addr=24'h00ABCD, p1_wdata=32'h12345678 -> one mem_req_write pulse with mem_data_in=32'h12345678, then p1_ack after mem_write_complete; p0_ack stays 0.
REQ-032 Starvation: both ports request continuously -> grant order p0,p0,p0,p0,p1,p0,... with STARVE_LIMIT=4.
REQ-033 Held completion: mem_data_valid held high for 3 cycles -> exactly one ack, and no new grant until mem_data_valid falls.
REQ-034 Timeout: no completion within 255 WAIT cycles -> ack with rdata=32'hDEADBEEF, timeout_err=1 (sticky); the next request is still serviced normally.
REQ-035 Reset in WAIT: rst_n pulsed low -> outputs 0 immediately (asynchronous), no ack; a later request completes correctly.
